// File: rtl/video_pkg.sv
// Shared types and constants for the video datapath Wishbone blocks.
package video_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_VGA  = 2'd1,
    GNT_MIRE = 2'd2
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Encoding of the one-bit "most recently granted" register.
  localparam logic PORT_VGA  = 1'b0;
  localparam logic PORT_MIRE = 1'b1;

endpackage

// File: rtl/wshb_mux.sv
// Combinational Wishbone steering: the granted master drives the SDRAM port,
// only the granted master sees ack, read data is broadcast to both.
module wshb_mux
  import video_pkg::*;
(
  input  arb_state_t  state,
  input  logic        force_eob,
  input  logic        vga_cyc,
  input  logic        vga_stb,
  input  logic        vga_we,
  input  logic [31:0] vga_adr,
  input  logic [31:0] vga_dat_ms,
  input  logic [3:0]  vga_sel,
  input  logic [2:0]  vga_cti,
  input  logic [1:0]  vga_bte,
  output logic        vga_ack,
  output logic [31:0] vga_dat_sm,
  input  logic        mire_cyc,
  input  logic        mire_stb,
  input  logic        mire_we,
  input  logic [31:0] mire_adr,
  input  logic [31:0] mire_dat_ms,
  input  logic [3:0]  mire_sel,
  input  logic [2:0]  mire_cti,
  input  logic [1:0]  mire_bte,
  output logic        mire_ack,
  output logic [31:0] mire_dat_sm,
  output logic        sdram_cyc,
  output logic        sdram_stb,
  output logic        sdram_we,
  output logic [31:0] sdram_adr,
  output logic [31:0] sdram_dat_ms,
  output logic [3:0]  sdram_sel,
  output logic [2:0]  sdram_cti,
  output logic [1:0]  sdram_bte,
  input  logic        sdram_ack,
  input  logic [31:0] sdram_dat_sm
);

  assign vga_dat_sm  = sdram_dat_sm;
  assign mire_dat_sm = sdram_dat_sm;

  // Route the granted master to the slave; IDLE parks the bus with cyc/stb low.
  always_comb begin
    sdram_cyc    = 1'b0;
    sdram_stb    = 1'b0;
    sdram_we     = 1'b0;
    sdram_adr    = '0;
    sdram_dat_ms = '0;
    sdram_sel    = '0;
    sdram_cti    = CTI_CLASSIC;
    sdram_bte    = '0;
    vga_ack      = 1'b0;
    mire_ack     = 1'b0;
    case (state)
      GNT_VGA: begin
        sdram_cyc    = vga_cyc;
        sdram_stb    = vga_stb;
        sdram_we     = vga_we;
        sdram_adr    = vga_adr;
        sdram_dat_ms = vga_dat_ms;
        sdram_sel    = vga_sel;
        sdram_cti    = force_eob ? CTI_EOB : vga_cti;
        sdram_bte    = vga_bte;
        vga_ack      = sdram_ack;
      end
      GNT_MIRE: begin
        sdram_cyc    = mire_cyc;
        sdram_stb    = mire_stb;
        sdram_we     = mire_we;
        sdram_adr    = mire_adr;
        sdram_dat_ms = mire_dat_ms;
        sdram_sel    = mire_sel;
        sdram_cti    = force_eob ? CTI_EOB : mire_cti;
        sdram_bte    = mire_bte;
        mire_ack     = sdram_ack;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wshb_arbiter.sv
// Two-master Wishbone arbiter (VGA reader, pattern writer) onto one SDRAM port.
// Round-robin on simultaneous requests, bursts capped at MAX_BURST acks when
// the other master is waiting, one IDLE cycle between any two grants.
module wshb_arbiter
  import video_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter bit VGA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_cyc,
  input  logic        vga_stb,
  input  logic        vga_we,
  input  logic [31:0] vga_adr,
  input  logic [31:0] vga_dat_ms,
  input  logic [3:0]  vga_sel,
  input  logic [2:0]  vga_cti,
  input  logic [1:0]  vga_bte,
  output logic        vga_ack,
  output logic [31:0] vga_dat_sm,
  input  logic        mire_cyc,
  input  logic        mire_stb,
  input  logic        mire_we,
  input  logic [31:0] mire_adr,
  input  logic [31:0] mire_dat_ms,
  input  logic [3:0]  mire_sel,
  input  logic [2:0]  mire_cti,
  input  logic [1:0]  mire_bte,
  output logic        mire_ack,
  output logic [31:0] mire_dat_sm,
  output logic        sdram_cyc,
  output logic        sdram_stb,
  output logic        sdram_we,
  output logic [31:0] sdram_adr,
  output logic [31:0] sdram_dat_ms,
  output logic [3:0]  sdram_sel,
  output logic [2:0]  sdram_cti,
  output logic [1:0]  sdram_bte,
  input  logic        sdram_ack,
  input  logic [31:0] sdram_dat_sm
);

  localparam int BW = $clog2(MAX_BURST);
  localparam logic [BW-1:0] BEATS_MAX = BW'(MAX_BURST - 1);
  localparam logic LAST_RESET = VGA_FIRST ? PORT_MIRE : PORT_VGA;

  arb_state_t    state;
  arb_state_t    state_next;
  logic          last;
  logic [BW-1:0] beats;
  logic          granted_cyc;
  logic          other_cyc;
  logic          fwd_ack;
  logic          preempt;

  // Request lines of the owner and of the contender, as seen from the current grant.
  always_comb begin
    granted_cyc = 1'b0;
    other_cyc   = 1'b0;
    case (state)
      GNT_VGA: begin
        granted_cyc = vga_cyc;
        other_cyc   = mire_cyc;
      end
      GNT_MIRE: begin
        granted_cyc = mire_cyc;
        other_cyc   = vga_cyc;
      end
      default: ;
    endcase
  end

  assign fwd_ack = sdram_ack && granted_cyc;
  assign preempt = (state != IDLE) && other_cyc && (beats == BEATS_MAX);

  // Next grant: round-robin out of IDLE, release on dropped cyc or on the capped ack.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (vga_cyc && mire_cyc) begin
          state_next = (last == PORT_VGA) ? GNT_MIRE : GNT_VGA;
        end else if (vga_cyc) begin
          state_next = GNT_VGA;
        end else if (mire_cyc) begin
          state_next = GNT_MIRE;
        end
      end
      GNT_VGA, GNT_MIRE: begin
        if (!granted_cyc || (preempt && sdram_ack)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant state, round-robin memory and beat counter; beats stays zero outside a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= LAST_RESET;
      beats <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next != IDLE) begin
        last <= (state_next == GNT_MIRE) ? PORT_MIRE : PORT_VGA;
      end
      if (state == IDLE || state_next == IDLE) begin
        beats <= '0;
      end else if (fwd_ack && beats != BEATS_MAX) begin
        beats <= beats + 1'b1;
      end
    end
  end

  wshb_mux u_mux (
    .state        (state),
    .force_eob    (preempt),
    .vga_cyc      (vga_cyc),
    .vga_stb      (vga_stb),
    .vga_we       (vga_we),
    .vga_adr      (vga_adr),
    .vga_dat_ms   (vga_dat_ms),
    .vga_sel      (vga_sel),
    .vga_cti      (vga_cti),
    .vga_bte      (vga_bte),
    .vga_ack      (vga_ack),
    .vga_dat_sm   (vga_dat_sm),
    .mire_cyc     (mire_cyc),
    .mire_stb     (mire_stb),
    .mire_we      (mire_we),
    .mire_adr     (mire_adr),
    .mire_dat_ms  (mire_dat_ms),
    .mire_sel     (mire_sel),
    .mire_cti     (mire_cti),
    .mire_bte     (mire_bte),
    .mire_ack     (mire_ack),
    .mire_dat_sm  (mire_dat_sm),
    .sdram_cyc    (sdram_cyc),
    .sdram_stb    (sdram_stb),
    .sdram_we     (sdram_we),
    .sdram_adr    (sdram_adr),
    .sdram_dat_ms (sdram_dat_ms),
    .sdram_sel    (sdram_sel),
    .sdram_cti    (sdram_cti),
    .sdram_bte    (sdram_bte),
    .sdram_ack    (sdram_ack),
    .sdram_dat_sm (sdram_dat_sm)
  );

endmodule
